// File: rtl/pipe_ctrl.sv
// Pipeline hazard / exception controller: global stalls, load-use bubbles,
// branch redirects, miss-align and memory bus-timeout exceptions.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0100,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255,
  parameter int          REG_ADDR_W  = 5,
  parameter int          WORD_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   if_busy,
  input  logic                   mem_busy,
  input  logic [REG_ADDR_W-1:0]  id_ra_addr,
  input  logic [REG_ADDR_W-1:0]  id_rb_addr,
  input  logic                   id_ra_used,
  input  logic                   id_rb_used,
  input  logic                   ex_en,
  input  logic                   ex_load,
  input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
  input  logic                   ex_gpr_we_,
  input  logic                   ex_br_taken,
  input  logic [WORD_ADDR_W-1:0] ex_br_addr,
  input  logic                   mem_en,
  input  logic                   miss_align,
  input  logic [WORD_ADDR_W-1:0] mem_pc,
  output logic                   if_stall,
  output logic                   id_stall,
  output logic                   ex_stall,
  output logic                   mem_stall,
  output logic                   if_flush,
  output logic                   id_flush,
  output logic                   ex_flush,
  output logic                   mem_flush,
  output logic                   pc_load,
  output logic [WORD_ADDR_W-1:0] new_pc,
  output logic [WORD_ADDR_W-1:0] epc,
  output logic [1:0]             exp_code,
  output logic                   exc_state
);

  typedef enum logic {RUN = 1'b0, EXC = 1'b1} state_e;

  state_e                 state_q;
  logic [7:0]             cnt_q;
  logic [WORD_ADDR_W-1:0] epc_q;
  logic [1:0]             expCode_q;

  logic gStall;
  logic timeoutHit;
  logic branchTaken;
  logic loadUse;

  assign gStall      = if_busy | mem_busy;
  // Fires on the cycle whose busy count would reach the limit.
  assign timeoutHit  = mem_busy && (({1'b0, cnt_q} + 9'd1) >= {1'b0, MEM_TIMEOUT});
  assign branchTaken = ex_en && ex_br_taken;
  assign loadUse     = ex_en && ex_load && !ex_gpr_we_ && (ex_dst_addr != '0) &&
                       ((id_ra_used && (id_ra_addr == ex_dst_addr)) ||
                        (id_rb_used && (id_rb_addr == ex_dst_addr)));

  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    pc_load   = 1'b0;
    new_pc    = '0;
    if (!reset_) begin
      pc_load = 1'b0;
    end else if (timeoutHit) begin
      mem_flush = 1'b1;
    end else if (gStall) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
    end else if (state_q == EXC) begin
      pc_load  = 1'b1;
      new_pc   = EXC_VECTOR[WORD_ADDR_W-1:0];
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (mem_en && miss_align) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (branchTaken) begin
      pc_load  = 1'b1;
      new_pc   = ex_br_addr;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (loadUse) begin
      if_stall = 1'b1;
      id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      epc_q     <= '0;
      expCode_q <= 2'b00;
    end else begin
      if (!mem_busy || timeoutHit) begin
        cnt_q <= '0;
      end else if (cnt_q < MEM_TIMEOUT) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // Timeout outranks everything, including a pending miss-align.
      if (timeoutHit) begin
        epc_q     <= mem_pc;
        expCode_q <= 2'b10;
        state_q   <= EXC;
      end else if (!gStall) begin
        case (state_q)
          EXC: state_q <= RUN;
          RUN: begin
            if (mem_en && miss_align) begin
              epc_q     <= mem_pc;
              expCode_q <= 2'b01;
              state_q   <= EXC;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign epc       = epc_q;
  assign exp_code  = expCode_q;
  assign exc_state = (state_q == EXC);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver pushes reference-model responses,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  localparam int TIMEOUT_LIMIT = 255;
  localparam logic [31:0] VECTOR_ADDR = 32'h0000_0100;

  typedef struct packed {
    logic        rst;
    logic        ifBusy;
    logic        memBusy;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        raUsed;
    logic        rbUsed;
    logic        exEn;
    logic        exLoad;
    logic [4:0]  dst;
    logic        gprWe_;
    logic        brTaken;
    logic [31:0] brAddr;
    logic        memEn;
    logic        missAlign;
    logic [31:0] memPc;
  } stim_t;

  // stall / flush bit order: {if, id, ex, mem}
  typedef struct packed {
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        pcLoad;
    logic [31:0] newPc;
    logic [31:0] epc;
    logic [1:0]  code;
    logic        exc;
  } resp_t;

  logic        clk;
  logic        reset_;
  logic        if_busy, mem_busy;
  logic [4:0]  id_ra_addr, id_rb_addr;
  logic        id_ra_used, id_rb_used;
  logic        ex_en, ex_load;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic        ex_br_taken;
  logic [31:0] ex_br_addr;
  logic        mem_en, miss_align;
  logic [31:0] mem_pc;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        pc_load;
  logic [31:0] new_pc;
  logic [31:0] epc;
  logic [1:0]  exp_code;
  logic        exc_state;

  pipe_ctrl dut (
    .clk(clk), .reset_(reset_),
    .if_busy(if_busy), .mem_busy(mem_busy),
    .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
    .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
    .ex_en(ex_en), .ex_load(ex_load), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_br_taken(ex_br_taken), .ex_br_addr(ex_br_addr),
    .mem_en(mem_en), .miss_align(miss_align), .mem_pc(mem_pc),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .pc_load(pc_load), .new_pc(new_pc), .epc(epc), .exp_code(exp_code),
    .exc_state(exc_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  resp_t expQ[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: exception pending flag, length of the current
  // mem_busy run, and the last recorded exception info.
  bit          mInExc = 1'b0;
  int          mBusyRun = 0;
  logic [31:0] mEpc = '0;
  logic [1:0]  mCode = 2'b00;

  // Outputs for this cycle follow from the rule priority; status outputs show
  // what was recorded at earlier edges, then the model advances one edge.
  task automatic modelStep(input stim_t s, output resp_t r);
    int  runNext;
    bit  hazard;
    r = '0;
    if (!s.rst) begin
      mInExc = 1'b0; mBusyRun = 0; mEpc = '0; mCode = 2'b00;
      return;
    end
    r.epc  = mEpc;
    r.code = mCode;
    r.exc  = mInExc;
    runNext = s.memBusy ? mBusyRun + 1 : 0;
    hazard = s.exEn && s.exLoad && !s.gprWe_ && (s.dst != 5'd0) &&
             ((s.raUsed && s.ra == s.dst) || (s.rbUsed && s.rb == s.dst));
    mBusyRun = runNext;
    if (s.memBusy && runNext >= TIMEOUT_LIMIT) begin
      r.flush = 4'b0001;
      mEpc = s.memPc; mCode = 2'b10; mInExc = 1'b1; mBusyRun = 0;
    end else if (s.ifBusy || s.memBusy) begin
      r.stall = 4'b1111;
    end else if (mInExc) begin
      r.pcLoad = 1'b1; r.newPc = VECTOR_ADDR; r.flush = 4'b1110;
      mInExc = 1'b0;
    end else if (s.memEn && s.missAlign) begin
      r.flush = 4'b1110;
      mEpc = s.memPc; mCode = 2'b01; mInExc = 1'b1;
    end else if (s.exEn && s.brTaken) begin
      r.pcLoad = 1'b1; r.newPc = s.brAddr; r.flush = 4'b1100;
    end else if (hazard) begin
      r.stall = 4'b1000; r.flush = 4'b0100;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    resp_t r;
    @(posedge clk);
    #1;
    reset_      = s.rst;
    if_busy     = s.ifBusy;
    mem_busy    = s.memBusy;
    id_ra_addr  = s.ra;
    id_rb_addr  = s.rb;
    id_ra_used  = s.raUsed;
    id_rb_used  = s.rbUsed;
    ex_en       = s.exEn;
    ex_load     = s.exLoad;
    ex_dst_addr = s.dst;
    ex_gpr_we_  = s.gprWe_;
    ex_br_taken = s.brTaken;
    ex_br_addr  = s.brAddr;
    mem_en      = s.memEn;
    miss_align  = s.missAlign;
    mem_pc      = s.memPc;
    modelStep(s, r);
    expQ.push_back(r);
  endtask

  task automatic checkOutput(input resp_t e);
    resp_t a;
    a.stall  = {if_stall, id_stall, ex_stall, mem_stall};
    a.flush  = {if_flush, id_flush, ex_flush, mem_flush};
    a.pcLoad = pc_load;
    a.newPc  = new_pc;
    a.epc    = epc;
    a.code   = exp_code;
    a.exc    = exc_state;
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("[TB] FAIL vector %0d outputs: got stall=%b flush=%b pcl=%b npc=%h epc=%h code=%b exc=%b, expected stall=%b flush=%b pcl=%b npc=%h epc=%h code=%b exc=%b",
               vectors, a.stall, a.flush, a.pcLoad, a.newPc, a.epc, a.code, a.exc,
               e.stall, e.flush, e.pcLoad, e.newPc, e.epc, e.code, e.exc);
    end
  endtask

  // Monitor: mid-cycle, compare whatever response the driver queued.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    s.gprWe_ = 1'b1;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst       = 1'b1;
    s.ifBusy    = ($urandom_range(0, 9) == 0);
    s.memBusy   = ($urandom_range(0, 9) == 0);
    s.ra        = 5'($urandom_range(0, 3));
    s.rb        = 5'($urandom_range(0, 3));
    s.raUsed    = 1'($urandom_range(0, 1));
    s.rbUsed    = 1'($urandom_range(0, 1));
    s.exEn      = ($urandom_range(0, 3) != 0);
    s.exLoad    = 1'($urandom_range(0, 1));
    s.dst       = 5'($urandom_range(0, 3));
    s.gprWe_    = ($urandom_range(0, 3) == 0);
    s.brTaken   = ($urandom_range(0, 3) == 0);
    s.brAddr    = $urandom & 32'hFFFF_FFFC;
    s.memEn     = 1'($urandom_range(0, 1));
    s.missAlign = ($urandom_range(0, 7) == 0);
    s.memPc     = $urandom;
    return s;
  endfunction

  initial begin
    stim_t s;
    reset_ = 1'b0;
    if_busy = 0; mem_busy = 0; id_ra_addr = 0; id_rb_addr = 0;
    id_ra_used = 0; id_rb_used = 0; ex_en = 0; ex_load = 0; ex_dst_addr = 0;
    ex_gpr_we_ = 1; ex_br_taken = 0; ex_br_addr = 0; mem_en = 0;
    miss_align = 0; mem_pc = 0;

    // Reset held with an active branch request: everything must stay zero.
    for (int i = 0; i < 2; i++) begin
      s = randStim(); s.rst = 1'b0; s.exEn = 1'b1; s.brTaken = 1'b1; s.ifBusy = 1'b0;
      applyStimulus(s);
    end
    applyStimulus(idleStim());

    // Load-use on r3, then the same pattern targeting r0.
    s = idleStim(); s.ra = 5'd3; s.raUsed = 1'b1; s.exEn = 1'b1; s.exLoad = 1'b1;
    s.dst = 5'd3; s.gprWe_ = 1'b0;
    applyStimulus(s);
    s.ra = 5'd0; s.dst = 5'd0;
    applyStimulus(s);
    s = idleStim(); s.rb = 5'd7; s.rbUsed = 1'b1; s.exEn = 1'b1; s.exLoad = 1'b1;
    s.dst = 5'd7; s.gprWe_ = 1'b0;
    applyStimulus(s);

    // Taken branch to 0x40, then branch plus load-use together.
    s = idleStim(); s.exEn = 1'b1; s.brTaken = 1'b1; s.brAddr = 32'h40;
    applyStimulus(s);
    s.exLoad = 1'b1; s.dst = 5'd3; s.gprWe_ = 1'b0; s.ra = 5'd3; s.raUsed = 1'b1;
    applyStimulus(s);

    // Miss-align at 0x1C, with a second miss-align arriving during EXC.
    s = idleStim(); s.memEn = 1'b1; s.missAlign = 1'b1; s.memPc = 32'h1C;
    applyStimulus(s);
    s.memPc = 32'h2C;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());

    // Miss-align under mem_busy is deferred until the bus frees up.
    s = idleStim(); s.memEn = 1'b1; s.missAlign = 1'b1; s.memPc = 32'h88; s.memBusy = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(s);
    s.memBusy = 1'b0;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());

    // Bus timeout after 255 busy cycles, with a miss-align on the last one.
    s = idleStim(); s.memBusy = 1'b1; s.memPc = 32'h0000_0A00;
    for (int i = 0; i < TIMEOUT_LIMIT; i++) begin
      if (i == TIMEOUT_LIMIT - 1) begin s.memEn = 1'b1; s.missAlign = 1'b1; end
      applyStimulus(s);
    end
    applyStimulus(idleStim());
    applyStimulus(idleStim());

    // Reset asserted while in EXC; no redirect once released.
    s = idleStim(); s.memEn = 1'b1; s.missAlign = 1'b1; s.memPc = 32'h64;
    applyStimulus(s);
    s = idleStim(); s.rst = 1'b0;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());

    for (int i = 0; i < 2000; i++) applyStimulus(randStim());

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d responses left unchecked, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: EXC_VECTOR, 32'h0000_0100, PC loaded on exception entry.
REQ-002 Parameter: MEM_TIMEOUT, 8'd255, max consecutive mem_busy cycles before bus-timeout exception.
REQ-003 Port: clk  input  1  clock; all state updates on posedge.
REQ-004 Port: reset_  input  1  asynchronous active-low reset.
REQ-005 Ports: if_busy, mem_busy  input  1 each  IF / MEM bus access not yet complete.
REQ-006 Ports: id_ra_addr, id_rb_addr  input  `REG_ADDR_BUS  ID source registers; id_ra_used, id_rb_used  input  1  source actually read.
REQ-007 Ports: ex_en, ex_load  input  1  EX valid, EX is a load; ex_dst_addr  input  `REG_ADDR_BUS; ex_gpr_we_  input  1  active-low write enable.
REQ-008 Ports: ex_br_taken  input  1; ex_br_addr  input  `WORD_ADDR_BUS  branch resolved in EX.
REQ-009 Ports: mem_en, miss_align  input  1; mem_pc  input  `WORD_ADDR_BUS  PC of instruction in MEM.
REQ-010 Ports: if_stall, id_stall, ex_stall, mem_stall  output  1  hold PC+if_reg, id_reg, ex_reg, mem_reg.
REQ-011 Ports: if_flush, id_flush, ex_flush, mem_flush  output  1  load bubble into that register (effective only when its stall=0).
REQ-012 Ports: pc_load  output  1; new_pc  output  `WORD_ADDR_BUS  PC redirect.
REQ-013 Ports: epc  output  `WORD_ADDR_BUS; exp_code  output  2  (00 none, 01 miss-align, 10 bus timeout); exc_state  output  1  (0 RUN, 1 EXC).

Function
REQ-014 gstall = if_busy | mem_busy; when gstall=1: all four stalls=1, all flushes=0, pc_load=0, no FSM transition except timeout (REQ-020).
REQ-015 Priority when gstall=0: EXC state > exception entry > branch > load-use > normal.
REQ-016 Exception entry (RUN, mem_en=1, miss_align=1): if/id/ex_flush=1, mem_flush=0; epc<=mem_pc, exp_code<=01, state->EXC next edge.
REQ-017 EXC state (one cycle): pc_load=1, new_pc=EXC_VECTOR, if/id/ex_flush=1; state->RUN next edge; epc/exp_code held until next exception.
REQ-018 Branch (ex_en & ex_br_taken): pc_load=1, new_pc=ex_br_addr, if_flush=1, id_flush=1; no stalls.
REQ-019 Load-use: ex_en & ex_load & ex_gpr_we_=0 & ex_dst_addr!=0 & ((id_ra_used & id_ra_addr==ex_dst_addr) | (id_rb_used & id_rb_addr==ex_dst_addr)) -> if_stall=1, id_flush=1, others 0; combinational, one bubble per hazard.
REQ-020 Timeout counter (8-bit): increments each cycle mem_busy=1, clears when mem_busy=0; on reaching MEM_TIMEOUT: epc<=mem_pc, exp_code<=10, state->EXC, counter cleared, mem_flush=1 and all stalls forced 0 that cycle.
REQ-021 Counter saturates at MEM_TIMEOUT; never wraps.
REQ-022 Miss-align and timeout same cycle: timeout wins (code 10).
REQ-023 miss_align while in EXC ignored (instruction already flushed).
REQ-024 Stall/flush/pc_load outputs combinational from inputs and state; zero cycle latency.

Reset
REQ-025 reset_=0 asynchronously: state=RUN, counter=0, epc=0, exp_code=00.
REQ-026 While reset_=0: all stall/flush/pc_load outputs=0, new_pc=0.
REQ-027 Reset during EXC: pc_load drops immediately; no redirect after release.

Verification
REQ-028 ID reads r3, EX load to r3 (we_=0) -> if_stall=1, id_flush=1 one cycle; r0 destination -> no stall.
REQ-029 ex_br_taken=1, ex_br_addr=0x40 -> pc_load=1, new_pc=0x40, if_flush=id_flush=1 same cycle.
REQ-030 miss_align=1, mem_pc=0x1C -> flushes that cycle; next cycle pc_load=1, new_pc=0x100, epc=0x1C, exp_code=01; then RUN.
REQ-031 mem_busy held 255 cycles -> all stalls=1 for 254 cycles, timeout on cycle 255: exp_code=10, EXC next cycle, pc_load to 0x100.
REQ-032 Branch and load-use together -> branch response only; miss_align with mem_busy=1 -> global stall, exception deferred until mem_busy=0.
REQ-033 Assert reset_=0 in EXC -> outputs zero immediately, state RUN, epc=0.
